// File: rtl/tail_light_sched_if.sv
// Lamp-bank bus: raw turn requests in, lamp pattern and status out.
// Master drives requests, slave (the sequencer) drives lamps and status.
interface tail_light_sched_if;
    logic       left;
    logic       right;
    logic [5:0] light;
    logic [1:0] mode;
    logic       step_tick;
    logic       seq_done;

    modport master (
        output left, right,
        input  light, mode, step_tick, seq_done
    );

    modport slave (
        input  left, right,
        output light, mode, step_tick, seq_done
    );
endinterface

// File: rtl/tail_light_sched.sv
// Tail-light sequencer: debounced left/right requests drive
// left/right sweeps or hazard flashing, paced by a prescaler.
module tail_light_sched #(
    parameter int TICK_DIV   = 4,
    parameter int DEB_CYCLES = 3
) (
    input logic          clk,
    input logic          reset,
    tail_light_sched_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] L1    = 4'd1;
    localparam logic [3:0] L2    = 4'd2;
    localparam logic [3:0] L3    = 4'd3;
    localparam logic [3:0] R1    = 4'd4;
    localparam logic [3:0] R2    = 4'd5;
    localparam logic [3:0] R3    = 4'd6;
    localparam logic [3:0] H_ON  = 4'd7;
    localparam logic [3:0] H_OFF = 4'd8;
    localparam logic [3:0] GAP   = 4'd9;

    logic [3:0]    state;
    logic [3:0]    nxt;
    logic [3:0]    decide;
    logic [PW-1:0] pre;
    logic [1:0]    raw;
    logic [1:0]    q;
    logic [CW-1:0] cnt [2];
    logic          tick;
    logic          last;
    logic [5:0]    light_r;
    logic [5:0]    light_nxt;
    logic [1:0]    mode_r;
    logic [1:0]    mode_nxt;

    assign raw = {bus.left, bus.right};

    // q[1] is the qualified left request, q[0] the right one
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    q[i]   <= raw[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign tick = (state != IDLE) && (pre == PRE_LAST);
    assign last = (state == L3) || (state == R3) || (state == H_OFF);

    always_comb begin
        decide = IDLE;
        unique case (1'b1)
            (q[1] &  q[0]): decide = H_ON;
            (q[1] & ~q[0]): decide = L1;
            (~q[1] & q[0]): decide = R1;
            default:        decide = IDLE;
        endcase
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = decide;
            L1:    nxt = tick ? L2    : L1;
            L2:    nxt = tick ? L3    : L2;
            L3:    nxt = tick ? GAP   : L3;
            R1:    nxt = tick ? R2    : R1;
            R2:    nxt = tick ? R3    : R2;
            R3:    nxt = tick ? GAP   : R3;
            H_ON:  nxt = tick ? H_OFF : H_ON;
            H_OFF: nxt = tick ? decide : H_OFF;
            GAP:   nxt = tick ? decide : GAP;
            default: nxt = IDLE;
        endcase
    end

    // GAP keeps the mode of the sequence that just finished
    always_comb begin
        light_nxt = 6'b000000;
        mode_nxt  = 2'b00;
        case (nxt)
            L1:    begin light_nxt = 6'b001000; mode_nxt = 2'b01; end
            L2:    begin light_nxt = 6'b011000; mode_nxt = 2'b01; end
            L3:    begin light_nxt = 6'b111000; mode_nxt = 2'b01; end
            R1:    begin light_nxt = 6'b000100; mode_nxt = 2'b10; end
            R2:    begin light_nxt = 6'b000110; mode_nxt = 2'b10; end
            R3:    begin light_nxt = 6'b000111; mode_nxt = 2'b10; end
            H_ON:  begin light_nxt = 6'b111111; mode_nxt = 2'b11; end
            H_OFF: begin light_nxt = 6'b000000; mode_nxt = 2'b11; end
            GAP:   begin light_nxt = 6'b000000; mode_nxt = mode_r; end
            default: begin light_nxt = 6'b000000; mode_nxt = 2'b00; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pre     <= '0;
            light_r <= '0;
            mode_r  <= '0;
        end else begin
            state   <= nxt;
            light_r <= light_nxt;
            mode_r  <= mode_nxt;
            if (nxt == IDLE || state == IDLE || pre == PRE_LAST)
                pre <= '0;
            else
                pre <= pre + 1'b1;
        end
    end

    assign bus.light     = light_r;
    assign bus.mode      = mode_r;
    assign bus.step_tick = tick;
    assign bus.seq_done  = tick & last;
endmodule

// File: tb/tb_tail_light_sched.sv
// Scenario bench for tail_light_sched: expected per-edge outputs are
// queued from the documented timeline and popped as edges occur.
module tb_tail_light_sched;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    typedef struct {
        int         e;
        logic [5:0] l;
        logic [1:0] m;
        logic       t;
        logic       d;
    } exp_t;

    exp_t sb[$];
    exp_t x;

    tail_light_sched_if bus ();

    tail_light_sched #(
        .TICK_DIV  (4),
        .DEB_CYCLES(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(int e, logic [5:0] l, logic [1:0] m,
                        logic t, logic d);
        exp_t y;
        y.e = e; y.l = l; y.m = m; y.t = t; y.d = d;
        sb.push_back(y);
    endtask

    task automatic start(logic l, logic r);
        reset     = 1'b1;
        bus.left  = l;
        bus.right = r;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.left  = 1'b0;
        bus.right = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.left  = i[0];
            bus.right = i[1];
            @(posedge clk);
            #1;
            total++;
            if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !== 10'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got l=%b m=%b t=%b d=%b want all 0",
                         i, bus.light, bus.mode, bus.step_tick, bus.seq_done);
            end
        end
        for (int e = 0; e < 24; e++) push(e, 6'b0, 2'b00, 1'b0, 1'b0);
        start(1'b0, 1'b0);
        for (int e = 0; e < 24; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL idle edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL idle_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_left_sweep();
        logic [5:0] l;
        for (int e = 0; e < 20; e++) begin
            l = (e < 3)  ? 6'b000000 : (e < 7)  ? 6'b001000 :
                (e < 11) ? 6'b011000 : (e < 15) ? 6'b111000 :
                (e < 19) ? 6'b000000 : 6'b001000;
            push(e, l, (e < 3) ? 2'b00 : 2'b01,
                 (e >= 3) && (e % 4 == 2), e == 14);
        end
        start(1'b1, 1'b0);
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL left edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL left_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_hazard();
        logic [5:0] l;
        for (int e = 0; e < 16; e++) begin
            l = (e < 3) ? 6'b000000 :
                (((e - 3) / 4) % 2 == 0) ? 6'b111111 : 6'b000000;
            push(e, l, (e < 3) ? 2'b00 : 2'b11,
                 (e >= 3) && (e % 4 == 2), e == 10);
        end
        start(1'b1, 1'b1);
        for (int e = 0; e < 16; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL hazard edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL hazard_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_drop_mid();
        logic [5:0] l;
        for (int e = 0; e < 31; e++) begin
            l = (e < 3)  ? 6'b000000 : (e < 7)  ? 6'b001000 :
                (e < 11) ? 6'b011000 : (e < 15) ? 6'b111000 : 6'b000000;
            push(e, l, (e >= 3 && e < 19) ? 2'b01 : 2'b00,
                 (e >= 3) && (e < 19) && (e % 4 == 2), e == 14);
        end
        start(1'b1, 1'b0);
        for (int e = 0; e < 31; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL drop edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
            if (e == 7) bus.left = 1'b0;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drop_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_glitch();
        for (int e = 0; e < 21; e++) push(e, 6'b0, 2'b00, 1'b0, 1'b0);
        start(1'b0, 1'b1);
        for (int e = 0; e < 21; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL glitch edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
            if (e == 1) bus.right = 1'b0;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL glitch_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] l;
        for (int e = 0; e < 9; e++) begin
            l = (e < 3) ? 6'b000000 : (e < 7) ? 6'b001000 : 6'b011000;
            push(e, l, (e < 3) ? 2'b00 : 2'b01,
                 (e >= 3) && (e % 4 == 2), 1'b0);
        end
        start(1'b1, 1'b0);
        for (int e = 0; e < 9; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL rmid_pre edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
        end
        reset = 1'b1;
        #1;
        total++;
        if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !== 10'b0) begin
            bad++;
            $display("FAIL rmid_async got %b/%b/%b/%b want all 0",
                     bus.light, bus.mode, bus.step_tick, bus.seq_done);
        end
        for (int e = 0; e < 8; e++) begin
            l = (e < 3) ? 6'b000000 : (e < 7) ? 6'b001000 : 6'b011000;
            push(e, l, (e < 3) ? 2'b00 : 2'b01,
                 (e >= 3) && (e % 4 == 2), 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].e == e) begin
                x = sb.pop_front();
                total++;
                if ({bus.light, bus.mode, bus.step_tick, bus.seq_done} !==
                    {x.l, x.m, x.t, x.d}) begin
                    bad++;
                    $display("FAIL rmid_post edge=%0d got %b/%b/%b/%b want %b/%b/%b/%b", e,
                             bus.light, bus.mode, bus.step_tick, bus.seq_done,
                             x.l, x.m, x.t, x.d);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rmid_leftover got %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.left  = 1'b0;
        bus.right = 1'b0;
        test_reset();
        test_left_sweep();
        test_hazard();
        test_drop_mid();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
